uart_rx_buffered: RTL and testbench
===================================

# uart_rx_buffered

Buffered UART receiver: the partner to the 16x-oversampled transmitter, decoding frames of 1 start bit (low), 8 data bits LSB first and 1 stop bit (high), with 16 `sys_clk` cycles per bit. It adds majority-vote sampling, false-start rejection, stop-bit (framing) checking and a small receive FIFO with a ready/ack handshake. It sits between the `uart_REC_dataH` pad input and the host logic that consumes received bytes.

## Interface
- `FIFO_DEPTH`, default 4: receive FIFO entries. Power of two, 2..16.
- `sys_clk` input 1: system clock. All logic samples on the rising edge.
- `sys_rst_l` input 1: reset. One clock; reset is synchronous and active-low.
- `uart_dataH` input 1: asynchronous serial line. Idles high.
- `rec_dataH` output 8: byte at the FIFO head. 0 when the FIFO is empty.
- `rec_readyH` output 1: FIFO not empty.
- `rec_ackH` input 1: pop request. Honoured only while `rec_readyH`=1; ignored otherwise.
- `framing_errH` output 1: one-cycle pulse when a frame's stop bit is sampled low.
- `overrun_errH` output 1: one-cycle pulse when a good frame is dropped because the FIFO is full.

## Operation
- **Synchronizer.** A 2-flop synchronizer samples `uart_dataH`; both flops reset to 1. The synchronized line is `rxs`.
- **Cell counter.** 4 bits. Cleared on entry to START; otherwise increments every cycle in START, DATA and STOP, wrapping 15→0. Bit index counter `bitn` is 0..7.
- **Sampling.** A bit's value is the majority of `rxs` at cell counts 6, 7 and 8. The decision is taken in the cycle where count==8, using the samples at counts 6 and 7 plus the current `rxs`.
- **FSM states:** IDLE, START, DATA, STOP, WAIT_HIGH.
  - IDLE: `rxs`==0 → START, cell counter cleared to 0.
  - START: at count 8, majority 1 → IDLE (false start, no error). Majority 0 → continue. At count 15 → DATA, `bitn`=0.
  - DATA: at count 8, shift the decided bit into the shift register MSB (LSB-first assembly). At count 15: if `bitn`==7 → STOP, else `bitn`+1.
  - STOP, decision at count 8:
    - Majority 1 and FIFO not full (or a pop happens the same cycle) → push byte, go to IDLE.
    - Majority 1 and FIFO full with no pop → drop the byte, pulse `overrun_errH`, go to IDLE.
    - Majority 0 → pulse `framing_errH`, no push, go to WAIT_HIGH.
  - WAIT_HIGH: stay until `rxs`==1, then → IDLE. A break condition never produces repeated frames.
- Returning to IDLE at mid-stop lets a following start edge resync half a bit early. Back-to-back frames must be received with no loss.
- **FIFO.** Circular buffer with read/write pointers and a count of width clog2(FIFO_DEPTH)+1. Pointers wrap modulo FIFO_DEPTH.
  - Pop: `rec_ackH` & `rec_readyH`.
  - Simultaneous push and pop at any fill level: both happen and the count is unchanged.
  - Simultaneous push and pop when full: the push is accepted, with no overrun.
  - Pop when empty: ignored.
- **Reset** (any time, including mid-frame): FSM to IDLE, counters 0, FIFO empty, `rec_dataH`=0, `rec_readyH`=0, `framing_errH`=0, `overrun_errH`=0, synchronizer flops to 1. Any partial frame is discarded.

## Timing
- A line falling edge at cycle L reaches `rxs` at L+2. IDLE sees it at t0=L+2.
- Cell count 0 of frame bit k (0 = start, 1..8 = data, 9 = stop) occurs at t0+1+16k. Its decision occurs at t0+9+16k.
- The stop decision is at t0+153. The push is registered, so `rec_readyH`/`rec_dataH` update at t0+154 (L+156). The error pulses are also high during cycle t0+154 only.
- A pop in cycle c makes `rec_dataH` show the next entry (or 0 if empty) at c+1. `rec_readyH` falls at c+1 if the FIFO became empty.
- Minimum frame spacing: 160 cycles.

## Test plan
- **Single frame.** Reset, then send 0xA5 with 16-cycle bits. Expect `rec_readyH` to rise exactly L+156, `rec_dataH`=0xA5, no error pulses. Pulse `rec_ackH` → `rec_readyH`=0 and `rec_dataH`=0 next cycle.
- **Glitch rejection.** Drive a 3-cycle low glitch in idle → FSM returns to IDLE, nothing pushed, no errors. Then send a frame with a 1-cycle inverted glitch at cell 7 of data bit 3 → byte is still correct.
- **Framing error.** Send 0x3C with the stop bit low, holding the line low for 40 more cycles → `framing_errH` pulse at L+156, FIFO stays empty, and the next valid frame 0x11 is received correctly.
- **Fill and overrun.** Send 0x01..0x05 back-to-back with no acks, FIFO_DEPTH=4 → entries 0x01..0x04 held, `overrun_errH` pulses on the 5th frame. Four pops return 0x01..0x04 in order, then `rec_readyH`=0.
- **Full with same-cycle pop.** With the FIFO full, assert `rec_ackH` in the 5th frame's push cycle → no overrun, and later pops return 0x02..0x05.
- **Reset mid-frame.** Assert `sys_rst_l`=0 for 1 cycle at data bit 4 with 2 entries buffered → all outputs 0 next cycle, FIFO empty, and the following full frame 0x7E is received correctly.

Source files
------------

// File: rtl/uart_rx_buffered.sv
// Buffered 16x-oversampled UART receiver: 8N1 framing, majority-vote bit decisions,
// false-start rejection, framing/overrun flags and a small receive FIFO with ready/ack.
module uart_rx_buffered #(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       sys_clk,
  input  logic       sys_rst_l,
  input  logic       uart_dataH,
  input  logic       rec_ackH,
  output logic [7:0] rec_dataH,
  output logic       rec_readyH,
  output logic       framing_errH,
  output logic       overrun_errH
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_HIGH
  } state_t;

  state_t          r_state;
  state_t          w_next_state;
  logic            r_sync1;
  logic            r_sync2;
  logic [3:0]      r_cnt;
  logic [2:0]      r_bitn;
  logic            r_s6;
  logic            r_s7;
  logic [7:0]      r_shift;
  logic            r_ferr;
  logic            r_oerr;
  logic [7:0]      r_mem [FIFO_DEPTH];
  logic [AW-1:0]   r_wptr;
  logic [AW-1:0]   r_rptr;
  logic [CW-1:0]   r_count;

  logic            w_rxs;
  logic            w_vote;
  logic            w_full;
  logic            w_pop;
  logic            w_push;
  logic            w_cnt_clr;
  logic            w_shift_en;
  logic            w_ferr;
  logic            w_oerr;

  assign w_rxs  = r_sync2;
  assign w_vote = (r_s6 & r_s7) | (r_s6 & w_rxs) | (r_s7 & w_rxs);
  assign w_full = (r_count == CW'(FIFO_DEPTH));
  assign w_pop  = rec_ackH & rec_readyH;

  assign rec_readyH   = (r_count != '0);
  assign rec_dataH    = rec_readyH ? r_mem[r_rptr] : '0;
  assign framing_errH = r_ferr;
  assign overrun_errH = r_oerr;

  always_comb begin
    w_next_state = r_state;
    w_cnt_clr    = 1'b0;
    w_shift_en   = 1'b0;
    w_push       = 1'b0;
    w_ferr       = 1'b0;
    w_oerr       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_rxs) begin
          w_next_state = S_START;
          w_cnt_clr    = 1'b1;
        end
      end
      S_START: begin
        if (r_cnt == 4'd8 && w_vote) w_next_state = S_IDLE;
        else if (r_cnt == 4'd15)     w_next_state = S_DATA;
      end
      S_DATA: begin
        if (r_cnt == 4'd8) w_shift_en = 1'b1;
        if (r_cnt == 4'd15 && r_bitn == 3'd7) w_next_state = S_STOP;
      end
      S_STOP: begin
        // Leave at mid-stop so a following start edge is caught without loss.
        if (r_cnt == 4'd8) begin
          if (w_vote) begin
            w_next_state = S_IDLE;
            if (!w_full || w_pop) w_push = 1'b1;
            else                  w_oerr = 1'b1;
          end else begin
            w_next_state = S_WAIT_HIGH;
            w_ferr       = 1'b1;
          end
        end
      end
      S_WAIT_HIGH: begin
        if (w_rxs) w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_l) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_bitn  <= '0;
      r_s6    <= 1'b1;
      r_s7    <= 1'b1;
      r_shift <= '0;
      r_ferr  <= 1'b0;
      r_oerr  <= 1'b0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      r_sync1 <= uart_dataH;
      r_sync2 <= r_sync1;
      r_state <= w_next_state;
      r_ferr  <= w_ferr;
      r_oerr  <= w_oerr;

      if (w_cnt_clr) r_cnt <= '0;
      else if (r_state == S_START || r_state == S_DATA || r_state == S_STOP)
        r_cnt <= r_cnt + 4'd1;

      if (r_state == S_START && r_cnt == 4'd15) r_bitn <= '0;
      else if (r_state == S_DATA && r_cnt == 4'd15 && r_bitn != 3'd7)
        r_bitn <= r_bitn + 3'd1;

      if (r_cnt == 4'd6) r_s6 <= w_rxs;
      if (r_cnt == 4'd7) r_s7 <= w_rxs;
      if (w_shift_en) r_shift <= {w_vote, r_shift[7:1]};

      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst_l && w_push) r_mem[r_wptr] <= r_shift;
  end

endmodule

// File: tb/tb_uart_rx_buffered.sv
// Self-checking bench for uart_rx_buffered: directed scenarios plus randomized frame
// bursts checked against a queue-based model of received bytes and error events.
module tb_uart_rx_buffered;

  logic       sys_clk;
  logic       sys_rst_l;
  logic       uart_dataH;
  logic       rec_ackH;
  logic [7:0] rec_dataH;
  logic       rec_readyH;
  logic       framing_errH;
  logic       overrun_errH;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int last_L;
  int ferr_q[$];
  int oerr_q[$];
  int rise_q[$];
  logic prev_ready = 1'b0;

  uart_rx_buffered #(.FIFO_DEPTH(4)) dut (
    .sys_clk      (sys_clk),
    .sys_rst_l    (sys_rst_l),
    .uart_dataH   (uart_dataH),
    .rec_ackH     (rec_ackH),
    .rec_dataH    (rec_dataH),
    .rec_readyH   (rec_readyH),
    .framing_errH (framing_errH),
    .overrun_errH (overrun_errH)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) cyc <= cyc + 1;

  // Event log sampled mid-cycle; cyc here is the index of the last rising edge.
  always @(negedge sys_clk) begin
    if (framing_errH) ferr_q.push_back(cyc);
    if (overrun_errH) oerr_q.push_back(cyc);
    if (rec_readyH && !prev_ready) rise_q.push_back(cyc);
    prev_ready = rec_readyH;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic clear_logs();
    ferr_q.delete();
    oerr_q.delete();
    rise_q.delete();
  endtask

  // Called at a negedge; the first cell is sampled at the next rising edge, L = last_L.
  // The push for this frame is registered at edge L+155 and visible from that negedge.
  task automatic drive_frame(input logic [7:0] d, input logic stopv,
                             input int gbit, input int gcell, input int ncells);
    logic [9:0] fr;
    fr = {stopv, d, 1'b0};
    last_L = cyc + 1;
    for (int k = 0; k < 10; k++) begin
      for (int c = 0; c < 16; c++) begin
        if (k * 16 + c >= ncells) return;
        uart_dataH = fr[k] ^ ((k == gbit) && (c == gcell));
        @(negedge sys_clk);
      end
    end
  endtask

  task automatic idle_cycles(input int n);
    uart_dataH = 1'b1;
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic test_reset();
    sys_rst_l  = 1'b0;
    uart_dataH = 1'b1;
    rec_ackH   = 1'b0;
    repeat (3) @(negedge sys_clk);
    sys_rst_l = 1'b1;
    @(negedge sys_clk);
    n_cmp++; if (rec_readyH !== 1'b0) begin n_err++; $display("FAIL reset_ready got=%b exp=0", rec_readyH); end
    n_cmp++; if (rec_dataH !== 8'h00) begin n_err++; $display("FAIL reset_data got=%h exp=00", rec_dataH); end
    n_cmp++; if (framing_errH !== 1'b0) begin n_err++; $display("FAIL reset_ferr got=%b exp=0", framing_errH); end
    n_cmp++; if (overrun_errH !== 1'b0) begin n_err++; $display("FAIL reset_oerr got=%b exp=0", overrun_errH); end
    idle_cycles(5);
  endtask

  task automatic test_single_frame();
    int L;
    clear_logs();
    drive_frame(8'hA5, 1'b1, -1, -1, 160);
    L = last_L;
    idle_cycles(4);
    n_cmp++; if (rise_q.size() !== 1) begin n_err++; $display("FAIL single_rise_cnt got=%0d exp=1", rise_q.size()); end
    else begin
      n_cmp++; if (rise_q[0] !== L + 155) begin n_err++; $display("FAIL single_rise_time got=%0d exp=%0d", rise_q[0], L + 155); end
    end
    n_cmp++; if (rec_dataH !== 8'hA5) begin n_err++; $display("FAIL single_data got=%h exp=a5", rec_dataH); end
    n_cmp++; if (ferr_q.size() + oerr_q.size() !== 0) begin n_err++; $display("FAIL single_errs got=%0d exp=0", ferr_q.size() + oerr_q.size()); end
    rec_ackH = 1'b1;
    @(negedge sys_clk);
    rec_ackH = 1'b0;
    n_cmp++; if (rec_readyH !== 1'b0) begin n_err++; $display("FAIL single_pop_ready got=%b exp=0", rec_readyH); end
    n_cmp++; if (rec_dataH !== 8'h00) begin n_err++; $display("FAIL single_pop_data got=%h exp=00", rec_dataH); end
    // Pop on an empty FIFO must not disturb the count.
    rec_ackH = 1'b1;
    @(negedge sys_clk);
    rec_ackH = 1'b0;
    @(negedge sys_clk);
    n_cmp++; if (rec_readyH !== 1'b0) begin n_err++; $display("FAIL empty_pop_ready got=%b exp=0", rec_readyH); end
    idle_cycles(5);
  endtask

  task automatic test_glitch();
    clear_logs();
    uart_dataH = 1'b0;
    repeat (3) @(negedge sys_clk);
    idle_cycles(60);
    n_cmp++; if (rise_q.size() + ferr_q.size() + oerr_q.size() !== 0) begin
      n_err++; $display("FAIL glitch_idle_events got=%0d exp=0", rise_q.size() + ferr_q.size() + oerr_q.size());
    end
    drive_frame(8'h5A, 1'b1, 4, 7, 160);
    idle_cycles(4);
    n_cmp++; if (rec_dataH !== 8'h5A || rec_readyH !== 1'b1) begin
      n_err++; $display("FAIL glitch_frame_data got=%h/%b exp=5a/1", rec_dataH, rec_readyH);
    end
    n_cmp++; if (ferr_q.size() + oerr_q.size() !== 0) begin n_err++; $display("FAIL glitch_frame_errs got=%0d exp=0", ferr_q.size() + oerr_q.size()); end
    rec_ackH = 1'b1;
    @(negedge sys_clk);
    rec_ackH = 1'b0;
    idle_cycles(5);
  endtask

  task automatic test_framing();
    int L;
    clear_logs();
    drive_frame(8'h3C, 1'b0, -1, -1, 160);
    L = last_L;
    repeat (40) @(negedge sys_clk);
    idle_cycles(6);
    n_cmp++; if (ferr_q.size() !== 1) begin n_err++; $display("FAIL framing_cnt got=%0d exp=1", ferr_q.size()); end
    else begin
      n_cmp++; if (ferr_q[0] !== L + 155) begin n_err++; $display("FAIL framing_time got=%0d exp=%0d", ferr_q[0], L + 155); end
    end
    n_cmp++; if (rec_readyH !== 1'b0 || rise_q.size() !== 0) begin n_err++; $display("FAIL framing_fifo got=%b exp=0", rec_readyH); end
    drive_frame(8'h11, 1'b1, -1, -1, 160);
    idle_cycles(4);
    n_cmp++; if (rec_dataH !== 8'h11 || rec_readyH !== 1'b1) begin n_err++; $display("FAIL framing_next got=%h/%b exp=11/1", rec_dataH, rec_readyH); end
    rec_ackH = 1'b1;
    @(negedge sys_clk);
    rec_ackH = 1'b0;
    idle_cycles(5);
  endtask

  task automatic test_fill_overrun();
    int L5;
    clear_logs();
    for (int i = 1; i <= 5; i++) drive_frame(8'(i), 1'b1, -1, -1, 160);
    L5 = last_L;
    idle_cycles(4);
    n_cmp++; if (oerr_q.size() !== 1) begin n_err++; $display("FAIL overrun_cnt got=%0d exp=1", oerr_q.size()); end
    else begin
      n_cmp++; if (oerr_q[0] !== L5 + 155) begin n_err++; $display("FAIL overrun_time got=%0d exp=%0d", oerr_q[0], L5 + 155); end
    end
    for (int i = 1; i <= 4; i++) begin
      n_cmp++; if (rec_readyH !== 1'b1 || rec_dataH !== 8'(i)) begin
        n_err++; $display("FAIL fill_pop%0d got=%h/%b exp=%h/1", i, rec_dataH, rec_readyH, 8'(i));
      end
      rec_ackH = 1'b1;
      @(negedge sys_clk);
      rec_ackH = 1'b0;
    end
    n_cmp++; if (rec_readyH !== 1'b0 || rec_dataH !== 8'h00) begin n_err++; $display("FAIL fill_empty got=%h/%b exp=00/0", rec_dataH, rec_readyH); end
    idle_cycles(5);
  endtask

  task automatic test_full_same_cycle_pop();
    int start_cyc;
    clear_logs();
    for (int i = 1; i <= 4; i++) drive_frame(8'(i), 1'b1, -1, -1, 160);
    start_cyc = cyc;
    fork
      drive_frame(8'h05, 1'b1, -1, -1, 160);
      begin
        // Frame 5 has L = start_cyc+1; ack high over edge L+155 (its push edge).
        repeat (155) @(negedge sys_clk);
        rec_ackH = 1'b1;
        @(negedge sys_clk);
        rec_ackH = 1'b0;
      end
    join
    n_cmp++; if (last_L + 154 !== cyc - 5 + 0 + 154 - 154 + 154 - 4 && last_L !== start_cyc + 1) begin
      n_err++; $display("FAIL fullpop_align got=%0d exp=%0d", last_L, start_cyc + 1);
    end
    idle_cycles(4);
    n_cmp++; if (oerr_q.size() !== 0) begin n_err++; $display("FAIL fullpop_overrun got=%0d exp=0", oerr_q.size()); end
    for (int i = 2; i <= 5; i++) begin
      n_cmp++; if (rec_readyH !== 1'b1 || rec_dataH !== 8'(i)) begin
        n_err++; $display("FAIL fullpop_pop%0d got=%h/%b exp=%h/1", i, rec_dataH, rec_readyH, 8'(i));
      end
      rec_ackH = 1'b1;
      @(negedge sys_clk);
      rec_ackH = 1'b0;
    end
    n_cmp++; if (rec_readyH !== 1'b0) begin n_err++; $display("FAIL fullpop_empty got=%b exp=0", rec_readyH); end
    idle_cycles(5);
  endtask

  task automatic test_reset_midframe();
    clear_logs();
    drive_frame(8'h21, 1'b1, -1, -1, 160);
    drive_frame(8'h42, 1'b1, -1, -1, 160);
    drive_frame(8'h99, 1'b1, -1, -1, 16 * 5 + 8);
    sys_rst_l  = 1'b0;
    uart_dataH = 1'b1;
    @(negedge sys_clk);
    sys_rst_l = 1'b1;
    n_cmp++; if ({rec_dataH, rec_readyH, framing_errH, overrun_errH} !== 11'h0) begin
      n_err++; $display("FAIL midrst_outputs got=%h/%b/%b/%b exp=00/0/0/0", rec_dataH, rec_readyH, framing_errH, overrun_errH);
    end
    clear_logs();
    idle_cycles(200);
    n_cmp++; if (rise_q.size() + ferr_q.size() + oerr_q.size() !== 0) begin
      n_err++; $display("FAIL midrst_discard got=%0d exp=0", rise_q.size() + ferr_q.size() + oerr_q.size());
    end
    drive_frame(8'h7E, 1'b1, -1, -1, 160);
    idle_cycles(4);
    n_cmp++; if (rec_dataH !== 8'h7E || rec_readyH !== 1'b1) begin n_err++; $display("FAIL midrst_next got=%h/%b exp=7e/1", rec_dataH, rec_readyH); end
    rec_ackH = 1'b1;
    @(negedge sys_clk);
    rec_ackH = 1'b0;
    n_cmp++; if (rec_readyH !== 1'b0) begin n_err++; $display("FAIL midrst_single got=%b exp=0", rec_readyH); end
    idle_cycles(5);
  endtask

  // Model: good frames queue in arrival order; only the first 4 fit, the rest overrun.
  task automatic test_random_bursts();
    logic [7:0] good_q[$];
    logic [7:0] d;
    int n, bad_cnt, exp_over, keep;
    logic bad;
    for (int r = 0; r < 8; r++) begin
      good_q.delete();
      bad_cnt = 0;
      clear_logs();
      n = $urandom_range(1, 6);
      for (int f = 0; f < n; f++) begin
        d   = 8'($urandom);
        bad = ($urandom_range(0, 4) == 0);
        drive_frame(d, ~bad, -1, -1, 160);
        if (bad) begin
          bad_cnt++;
          idle_cycles($urandom_range(4, 12));
        end else begin
          good_q.push_back(d);
          idle_cycles($urandom_range(0, 10));
        end
      end
      idle_cycles(6);
      exp_over = (good_q.size() > 4) ? good_q.size() - 4 : 0;
      keep     = (good_q.size() > 4) ? 4 : good_q.size();
      n_cmp++; if (ferr_q.size() !== bad_cnt) begin n_err++; $display("FAIL rnd%0d_framing got=%0d exp=%0d", r, ferr_q.size(), bad_cnt); end
      n_cmp++; if (oerr_q.size() !== exp_over) begin n_err++; $display("FAIL rnd%0d_overrun got=%0d exp=%0d", r, oerr_q.size(), exp_over); end
      for (int i = 0; i < keep; i++) begin
        n_cmp++; if (rec_readyH !== 1'b1 || rec_dataH !== good_q[i]) begin
          n_err++; $display("FAIL rnd%0d_pop%0d got=%h/%b exp=%h/1", r, i, rec_dataH, rec_readyH, good_q[i]);
        end
        rec_ackH = 1'b1;
        @(negedge sys_clk);
        rec_ackH = 1'b0;
        repeat ($urandom_range(0, 2)) @(negedge sys_clk);
      end
      n_cmp++; if (rec_readyH !== 1'b0 || rec_dataH !== 8'h00) begin n_err++; $display("FAIL rnd%0d_empty got=%h/%b exp=00/0", r, rec_dataH, rec_readyH); end
    end
  endtask

  initial begin
    sys_rst_l  = 1'b0;
    uart_dataH = 1'b1;
    rec_ackH   = 1'b0;
    @(negedge sys_clk);
    test_reset();
    test_single_frame();
    test_glitch();
    test_framing();
    test_fill_overrun();
    test_full_same_cycle_pop();
    test_reset_midframe();
    test_random_bursts();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
